// File: rtl/wb_write_queue_if.sv
// Bus bundle for wb_write_queue: push side, register-file write port,
// two forwarding lookup ports and the occupancy count.
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_addr;
    logic [XLEN-1:0]  in_data;
    logic             flush;
    logic             rf_busy;
    logic             write_enable;
    logic [4:0]       addr_rd;
    logic [XLEN-1:0]  data_rd;
    logic [4:0]       fwd_addr_rs1;
    logic             fwd_hit_rs1;
    logic [XLEN-1:0]  fwd_data_rs1;
    logic [4:0]       fwd_addr_rs2;
    logic             fwd_hit_rs2;
    logic [XLEN-1:0]  fwd_data_rs2;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_addr, in_data, flush, rf_busy, fwd_addr_rs1, fwd_addr_rs2,
        input  in_ready, write_enable, addr_rd, data_rd,
               fwd_hit_rs1, fwd_data_rs1, fwd_hit_rs2, fwd_data_rs2, count
    );

    modport slave (
        input  in_valid, in_addr, in_data, flush, rf_busy, fwd_addr_rs1, fwd_addr_rs2,
        output in_ready, write_enable, addr_rd, data_rd,
               fwd_hit_rs1, fwd_data_rs1, fwd_hit_rs2, fwd_data_rs2, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order register-file write queue with rs1/rs2 forwarding of pending writes.
// Optional WB_COALESCE_EN: a push to the same register as the youngest entry merges in place.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    wb_write_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] data;
    } fwd_t;

    logic [4:0]       r_addr [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_coalesce;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_alloc;
    logic             w_merge;
    logic [PTR_W-1:0] w_young;
    fwd_t             w_fwd1;
    fwd_t             w_fwd2;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = !w_empty && !bus.rf_busy && !bus.flush;
    assign w_young = r_tail - PTR_W'(1);

`ifdef WB_COALESCE_EN
    // A single entry that is leaving this cycle cannot absorb the new value.
    assign w_coalesce = !w_empty && (bus.in_addr != 5'd0) && (r_addr[w_young] == bus.in_addr)
                        && !((r_count == CNT_W'(1)) && w_pop);
`else
    assign w_coalesce = 1'b0;
`endif

    assign w_in_ready = !w_full || w_coalesce;
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;
    assign w_alloc    = w_accept && (bus.in_addr != 5'd0) && !w_coalesce;
    assign w_merge    = w_accept && w_coalesce;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop)   r_head <= r_head + PTR_W'(1);
            if (w_alloc) r_tail <= r_tail + PTR_W'(1);
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: entry storage has no reset; validity comes solely from head/count.
    always_ff @(posedge clock) begin
        if (w_alloc) begin
            r_addr[r_tail] <= bus.in_addr;
            r_data[r_tail] <= bus.in_data;
        end else if (w_merge) begin
            r_data[w_young] <= bus.in_data;
        end
    end

    // Scan oldest to youngest so the last match is the newest value.
    function automatic fwd_t fwd_lookup(input logic [4:0] addr);
        fwd_t             res;
        logic [PTR_W-1:0] idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + PTR_W'(k);
            if ((addr != 5'd0) && (CNT_W'(k) < r_count) && (r_addr[idx] == addr)) begin
                res.hit  = 1'b1;
                res.data = r_data[idx];
            end
        end
        return res;
    endfunction

    // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
    always_comb begin
        w_fwd1 = '0;
        w_fwd2 = '0;
        w_fwd1 = fwd_lookup(bus.fwd_addr_rs1);
        w_fwd2 = fwd_lookup(bus.fwd_addr_rs2);
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.write_enable = w_pop;
    assign bus.addr_rd      = w_empty ? 5'd0 : r_addr[r_head];
    assign bus.data_rd      = w_empty ? '0   : r_data[r_head];
    assign bus.fwd_hit_rs1  = w_fwd1.hit;
    assign bus.fwd_data_rs1 = w_fwd1.data;
    assign bus.fwd_hit_rs2  = w_fwd2.hit;
    assign bus.fwd_data_rs2 = w_fwd2.data;
    assign bus.count        = r_count;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH=4, XLEN=32).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_wb_write_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    wb_write_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [4:0] addr, input logic [XLEN-1:0] data);
        bus.in_valid = 1'b1;
        bus.in_addr  = addr;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".count"}, 64'(bus.count), 64'd0);
        check({tag, ".we"}, 64'(bus.write_enable), 64'd0);
        check({tag, ".addr_rd"}, 64'(bus.addr_rd), 64'd0);
        check({tag, ".data_rd"}, 64'(bus.data_rd), 64'd0);
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, ".hit1"}, 64'(bus.fwd_hit_rs1), 64'd0);
        check({tag, ".fwd1"}, 64'(bus.fwd_data_rs1), 64'd0);
        check({tag, ".hit2"}, 64'(bus.fwd_hit_rs2), 64'd0);
        check({tag, ".fwd2"}, 64'(bus.fwd_data_rs2), 64'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_addr      = 5'd0;
        bus.in_data      = '0;
        bus.flush        = 1'b0;
        bus.rf_busy      = 1'b0;
        bus.fwd_addr_rs1 = 5'd0;
        bus.fwd_addr_rs2 = 5'd0;

        // Reset state
        #3;
        check_idle("reset");
        #4 reset_n = 1'b1;
        tick();

        // Single write: one cycle of latency, then drained
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd5;
        bus.in_data  = 32'h11;
        #1 check("single.in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("single.we", 64'(bus.write_enable), 64'd1);
        check("single.addr", 64'(bus.addr_rd), 64'd5);
        check("single.data", 64'(bus.data_rd), 64'h11);
        check("single.count", 64'(bus.count), 64'd1);
        tick();
        check("single.count_after", 64'(bus.count), 64'd0);
        check("single.we_after", 64'(bus.write_enable), 64'd0);

        // Fill under rf_busy, reject extra push, drain in order
        bus.rf_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'hA0 + 32'(i));
        bus.in_addr = 5'd9;
        #1;
        check("full.count", 64'(bus.count), 64'd4);
        check("full.in_ready", 64'(bus.in_ready), 64'd0);
        check("full.we_busy", 64'(bus.write_enable), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h99;
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("full.count_held", 64'(bus.count), 64'd4);
        check("full.head", 64'(bus.addr_rd), 64'd1);
        bus.rf_busy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("drain%0d.we", i), 64'(bus.write_enable), 64'd1);
            check($sformatf("drain%0d.addr", i), 64'(bus.addr_rd), 64'(i));
            check($sformatf("drain%0d.data", i), 64'(bus.data_rd), 64'hA0 + 64'(i));
            tick();
        end
        #1;
        check("drain.count", 64'(bus.count), 64'd0);
        check("drain.we", 64'(bus.write_enable), 64'd0);
        tick();

        // Forwarding: youngest of two x3 entries wins, x0 never hits, in_* invisible
        bus.rf_busy = 1'b1;
        push(5'd3, 32'h30);
        push(5'd6, 32'h60);
        push(5'd3, 32'h31);
        bus.fwd_addr_rs1 = 5'd3;
        bus.fwd_addr_rs2 = 5'd0;
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd3;
        bus.in_data  = 32'h77;
        #1;
        check("fwd.count", 64'(bus.count), 64'd3);
        check("fwd.hit1", 64'(bus.fwd_hit_rs1), 64'd1);
        check("fwd.data1", 64'(bus.fwd_data_rs1), 64'h31);
        check("fwd.hit2_x0", 64'(bus.fwd_hit_rs2), 64'd0);
        check("fwd.data2_x0", 64'(bus.fwd_data_rs2), 64'd0);
        bus.in_valid = 1'b0;
        bus.fwd_addr_rs2 = 5'd6;
        bus.fwd_addr_rs1 = 5'd7;
        #1;
        check("fwd.data2_x6", 64'(bus.fwd_data_rs2), 64'h60);
        check("fwd.hit1_miss", 64'(bus.fwd_hit_rs1), 64'd0);
        check("fwd.data1_miss", 64'(bus.fwd_data_rs1), 64'd0);

        // Flush with 3 pending and a simultaneous push
        bus.flush    = 1'b1;
        bus.rf_busy  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd8;
        bus.in_data  = 32'h88;
        #1 check("flush.we", 64'(bus.write_enable), 64'd0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.fwd_addr_rs1 = 5'd8;
        bus.fwd_addr_rs2 = 5'd3;
        #1;
        check_idle("flush");
        tick();
        check("flush.we_later", 64'(bus.write_enable), 64'd0);

        // x0 push: handshake only, nothing allocated
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd0;
        bus.in_data  = 32'hFFFF_FFFF;
        #1 check("x0.in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("x0.count", 64'(bus.count), 64'd0);
        check("x0.we", 64'(bus.write_enable), 64'd0);
        tick();
        check("x0.we_later", 64'(bus.write_enable), 64'd0);

        // Head being written is still forwarded; push and pop in the same cycle
        push(5'd12, 32'hC);
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd13;
        bus.in_data  = 32'hD;
        bus.fwd_addr_rs1 = 5'd12;
        #1;
        check("pp.we", 64'(bus.write_enable), 64'd1);
        check("pp.hit_head", 64'(bus.fwd_hit_rs1), 64'd1);
        check("pp.fwd_head", 64'(bus.fwd_data_rs1), 64'hC);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("pp.count", 64'(bus.count), 64'd1);
        check("pp.addr", 64'(bus.addr_rd), 64'd13);
        check("pp.data", 64'(bus.data_rd), 64'hD);
        tick();
        check("pp.count_after", 64'(bus.count), 64'd0);

        // Asynchronous reset in the middle of a drain
        bus.rf_busy = 1'b1;
        push(5'd10, 32'h1);
        push(5'd11, 32'h2);
        bus.rf_busy = 1'b0;
        bus.fwd_addr_rs1 = 5'd10;
        bus.fwd_addr_rs2 = 5'd11;
        #1;
        check("arst.count_pre", 64'(bus.count), 64'd2);
        check("arst.we_pre", 64'(bus.write_enable), 64'd1);
        #1 reset_n = 1'b0;
        #1 check_idle("arst");
        #1 reset_n = 1'b1;
        tick();

        // Back-to-back writes to the same register
        bus.rf_busy = 1'b1;
        push(5'd7, 32'h1);
        push(5'd7, 32'h2);
        bus.rf_busy = 1'b0;
        #1;
`ifdef WB_COALESCE_EN
        check("same.count", 64'(bus.count), 64'd1);
        check("same.addr", 64'(bus.addr_rd), 64'd7);
        check("same.data", 64'(bus.data_rd), 64'h2);
        tick();
`else
        check("same.count", 64'(bus.count), 64'd2);
        check("same.data_first", 64'(bus.data_rd), 64'h1);
        tick();
        check("same.addr", 64'(bus.addr_rd), 64'd7);
        check("same.data_last", 64'(bus.data_rd), 64'h2);
        tick();
`endif
        check("same.count_after", 64'(bus.count), 64'd0);

`ifdef WB_COALESCE_EN
        // Coalescing into a full queue
        bus.rf_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'hA0 + 32'(i));
        bus.in_addr = 5'd4;
        #1 check("cfull.ready_match", 64'(bus.in_ready), 64'd1);
        push(5'd4, 32'h44);
        bus.in_addr = 5'd5;
        #1;
        check("cfull.count", 64'(bus.count), 64'd4);
        check("cfull.ready_nomatch", 64'(bus.in_ready), 64'd0);
        bus.rf_busy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("cfull%0d.addr", i), 64'(bus.addr_rd), 64'(i));
            check($sformatf("cfull%0d.data", i), 64'(bus.data_rd),
                  (i == 4) ? 64'h44 : 64'hA0 + 64'(i));
            tick();
        end
        check("cfull.count_after", 64'(bus.count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
